// File: rtl/frame_buf_pkg.sv
// Shared definitions for the 176x144 RGB332 frame buffer: geometry, colours,
// capture FSM encoding and the colour-bar lookup used by the test pattern.
package frame_buf_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int FB_ADDR_W     = 15;

    localparam logic [7:0] RGB332_WHITE   = 8'hFF;
    localparam logic [7:0] RGB332_YELLOW  = 8'hFC;
    localparam logic [7:0] RGB332_CYAN    = 8'h1F;
    localparam logic [7:0] RGB332_GREEN   = 8'h1C;
    localparam logic [7:0] RGB332_MAGENTA = 8'hE3;
    localparam logic [7:0] RGB332_RED     = 8'hE0;
    localparam logic [7:0] RGB332_BLUE    = 8'h03;
    localparam logic [7:0] RGB332_BLACK   = 8'h00;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } fw_state_t;

    // Eight 22-pixel bars; a compare chain avoids a divider for x/22.
    function automatic logic [7:0] bar_colour(input logic [7:0] x);
        logic [7:0] c;
        if      (x < 8'd22)  c = RGB332_WHITE;
        else if (x < 8'd44)  c = RGB332_YELLOW;
        else if (x < 8'd66)  c = RGB332_CYAN;
        else if (x < 8'd88)  c = RGB332_GREEN;
        else if (x < 8'd110) c = RGB332_MAGENTA;
        else if (x < 8'd132) c = RGB332_RED;
        else if (x < 8'd154) c = RGB332_BLUE;
        else                 c = RGB332_BLACK;
        return c;
    endfunction

endpackage

// File: rtl/rgb565_to_rgb332.sv
// Packs an RGB565 byte pair into RGB332; with FRAME_WRITER_TEST_PATTERN_EN
// defined the output is replaced by vertical colour bars selected by x.
module rgb565_to_rgb332
    import frame_buf_pkg::*;
(
`ifdef FRAME_WRITER_TEST_PATTERN_EN
    input  logic [7:0] x,
`endif
    input  logic [5:0] b1_bits,
    input  logic [1:0] b2_bits,
    output logic [7:0] pixel
);

`ifdef FRAME_WRITER_TEST_PATTERN_EN
    assign pixel = bar_colour(x);
`else
    // b1_bits holds {R[4:2], G[5:3]} from the first byte; b2_bits is B[4:3].
    assign pixel = {b1_bits, b2_bits};
`endif

endmodule

// File: rtl/ov7670_frame_writer.sv
// OV7670 QCIF RGB565 capture into the RGB332 frame buffer write port.
// Optional colour-bar output via FRAME_WRITER_TEST_PATTERN_EN.
module ov7670_frame_writer
    import frame_buf_pkg::*;
#(
    parameter int WIDTH  = SCREEN_WIDTH,
    parameter int HEIGHT = SCREEN_HEIGHT,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data,
    output logic              w_en,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count,
    output logic [1:0]        fsm_state
);

    localparam int X_W = $clog2(WIDTH + 1);
    localparam int Y_W = $clog2(HEIGHT + 1);
    localparam logic [X_W-1:0]    X_LIM     = X_W'(WIDTH);
    localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

    fw_state_t         state;
    fw_state_t         state_next;
    logic              frame_start;
    logic              frame_end;
    logic              capture;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic              line_seen;
    logic [5:0]        b1_bits;
    logic [7:0]        pixel;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_next;
    end

    // A capture only begins after a complete vsync high->low, so a reset
    // mid-frame always resynchronises on the next frame boundary.
    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (vsync)  state_next = BLANK;
            BLANK:   if (!vsync) state_next = ACTIVE;
            ACTIVE:  if (vsync)  state_next = BLANK;
            default: state_next = SYNC;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_end   = 1'b0;
        capture     = 1'b0;
        case (state)
            BLANK:   frame_start = !vsync;
            ACTIVE: begin
                frame_end = vsync;
                capture   = !vsync;
            end
            default: ;
        endcase
    end

    rgb565_to_rgb332 u_pack (
`ifdef FRAME_WRITER_TEST_PATTERN_EN
        .x       (8'(x)),
`endif
        .b1_bits (b1_bits),
        .b2_bits (d[4:3]),
        .pixel   (pixel)
    );

    // w_en is a single-cycle strobe; w_addr/w_data are valid only while it is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_addr     <= '0;
            w_data     <= '0;
            w_en       <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            line_seen  <= 1'b0;
            b1_bits    <= '0;
        end else begin
            w_en       <= 1'b0;
            frame_done <= frame_end;
            if (frame_start) begin
                x         <= '0;
                y         <= '0;
                line_base <= '0;
                phase     <= 1'b0;
                line_seen <= 1'b0;
                pix_count <= '0;
            end else if (capture) begin
                if (href) begin
                    line_seen <= 1'b1;
                    phase     <= !phase;
                    if (!phase) begin
                        b1_bits <= {d[7:5], d[2:0]};
                    end else if (x < X_LIM) begin
                        x <= x + X_W'(1);
                        if (y < Y_LIM) begin
                            w_en      <= 1'b1;
                            w_addr    <= line_base + ADDR_W'(x);
                            w_data    <= pixel;
                            pix_count <= pix_count + ADDR_W'(1);
                        end
                    end
                end else if (line_seen) begin
                    // Line end: an unpaired trailing byte is dropped with phase.
                    line_seen <= 1'b0;
                    x         <= '0;
                    phase     <= 1'b0;
                    if (y < Y_LIM) begin
                        y         <= y + Y_W'(1);
                        line_base <= line_base + LINE_STEP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer: reset, single lines, overlong lines,
// full and overlong frames, with expected writes held in a queue.
module tb_ov7670_frame_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic [14:0] w_addr;
    logic [7:0]  w_data;
    logic        w_en;
    logic        frame_done;
    logic [14:0] pix_count;
    logic [1:0]  fsm_state;

    ov7670_frame_writer dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_en       (w_en),
        .frame_done (frame_done),
        .pix_count  (pix_count),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    // Byte pairs and their hand-packed RGB332 values.
    logic [7:0] tb_b1 [4] = '{8'hF8, 8'h07, 8'hA5, 8'hFF};
    logic [7:0] tb_b2 [4] = '{8'h1F, 8'hE0, 8'h5A, 8'h00};
    logic [7:0] tb_px [4] = '{8'hE3, 8'h1C, 8'hB7, 8'hFC};
    logic [7:0] bars  [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    logic [22:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int m_x = 0;
    int m_y = 0;
    bit m_active = 1'b0;
    int last_addr = -1;
    int max_addr = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int idx, input int xpos);
`ifdef FRAME_WRITER_TEST_PATTERN_EN
        return bars[xpos / 22];
`else
        return tb_px[idx];
`endif
    endfunction

    task automatic cyc(input logic v, input logic h, input logic [7:0] dd);
        vsync = v;
        href  = h;
        d     = dd;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (w_en) begin
            last_addr = int'(w_addr);
            if (int'(w_addr) > max_addr) max_addr = int'(w_addr);
            if (exp_q.size() == 0) begin
                check("spurious_wen", w_en, 1'b0);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                check("w_addr", w_addr, e[22:8]);
                check("w_data", w_data, e[7:0]);
            end
        end
    end

    task automatic send_pair(input int idx);
        bit wr;
        wr = m_active && (m_x < 176) && (m_y < 144);
        if (wr) exp_q.push_back({15'(m_y * 176 + m_x), exp_pix(idx, m_x)});
        cyc(1'b0, 1'b1, tb_b1[idx]);
        check("wen_after_b1", w_en, 1'b0);
        cyc(1'b0, 1'b1, tb_b2[idx]);
        check("wen_after_b2", w_en, wr);
        if (m_active && m_x < 176) m_x++;
    endtask

    task automatic send_line(input int npairs, input bit odd, input int idx);
        for (int i = 0; i < npairs; i++) send_pair(idx);
        if (odd) cyc(1'b0, 1'b1, tb_b1[idx]);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        if (m_active) begin
            m_x = 0;
            if (m_y < 144) m_y++;
        end
    endtask

    task automatic start_frame;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        m_active = 1'b1;
        m_x = 0;
        m_y = 0;
        check("active_entry_state", fsm_state, 2'd2);
        check("pix_count_cleared", pix_count, 0);
    endtask

    task automatic end_frame(input int exp_count);
        cyc(1'b1, 1'b0, 8'h00);
        m_active = 1'b0;
        check("frame_done_pulse", frame_done, 1'b1);
        check("pix_count_frame", pix_count, exp_count);
        check("blank_state", fsm_state, 2'd1);
        cyc(1'b1, 1'b0, 8'h00);
        check("frame_done_single", frame_done, 1'b0);
        // HREF during vertical blanking must not write.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(i * 37));
        cyc(1'b1, 1'b0, 8'h00);
        check("pix_count_hold", pix_count, exp_count);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_w_en", w_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_state", fsm_state, 2'd0);
        reset = 1'b0;

        // Partial line, then reset held for 3 cycles mid-line.
        start_frame();
        for (int i = 0; i < 5; i++) send_pair(2);
        cyc(1'b0, 1'b1, tb_b1[0]);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        check("midrst_w_addr", w_addr, 0);
        check("midrst_w_data", w_data, 0);
        check("midrst_w_en", w_en, 0);
        check("midrst_pix_count", pix_count, 0);
        check("midrst_state", fsm_state, 2'd0);
        reset = 1'b0;
        m_active = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(i);
        cyc(1'b0, 1'b0, 8'h00);
        check("no_capture_before_vsync", pix_count, 0);

        // One full-width line of 0xF8/0x1F pairs.
        start_frame();
        send_line(176, 1'b0, 0);
        end_frame(176);

        // Overlong line with an odd trailing byte, then a short line.
        start_frame();
        send_line(200, 1'b1, 1);
        send_line(3, 1'b0, 2);
        end_frame(179);

        // 150 lines: only the first 144 are stored.
        last_addr = -1;
        max_addr  = -1;
        start_frame();
        for (int l = 0; l < 150; l++) send_line(176, 1'b0, l % 4);
        end_frame(25344);
        check("last_w_addr", last_addr, 25343);
        check("max_w_addr", max_addr, 25343);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
